// File: rtl/mcc_job_arbiter.sv
// mcc_job_arbiter: two-requester round-robin job sequencer for the
// shared multi_cycle_circuit datapath, with timeout recovery.
//
// Ports:
//   clock, reset            sole clock, synchronous active-high reset
//   req[1:0]                per-requester job pending (held until ack)
//   req_mode[1:0]           per-requester mode bit
//   req_a..req_d[15:0]      requester i operand in bits [8i+7:8i]
//   ack[1:0]                one-cycle pulse when operands are latched
//   rsp_valid[1:0]          one-cycle pulse when the owner's job ends
//   rsp_result[7:0]         job result (0 on timeout)
//   rsp_err                 high with rsp_valid on timeout
//   busy                    high whenever the sequencer is not idle
//   mcc_start, mcc_mode     datapath start / mode
//   mcc_a..mcc_d[7:0]       datapath operands, stable for a whole job
//   mcc_reset               datapath reset (reset or recovery pulse)
//   mcc_done, mcc_result    datapath completion and result
module mcc_job_arbiter #(
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  req_mode,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [15:0] req_c,
  input  logic [15:0] req_d,
  output logic [1:0]  ack,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_result,
  output logic        rsp_err,
  output logic        busy,
  output logic        mcc_start,
  output logic        mcc_mode,
  output logic [7:0]  mcc_a,
  output logic [7:0]  mcc_b,
  output logic [7:0]  mcc_c,
  output logic [7:0]  mcc_d,
  output logic        mcc_reset,
  input  logic        mcc_done,
  input  logic [7:0]  mcc_result
);

  localparam int SW = $clog2(START_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_LOW,
    WAIT_HIGH,
    RESP,
    RECOVER
  } state_t;

  state_t        state, state_n;
  logic          gnt, gnt_n;
  logic          last, last_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [1:0]    ack_n, rv_n;
  logic [7:0]    res_n;
  logic          err_n, busy_n;
  logic          start_n, mode_n;
  logic [7:0]    a_n, b_n, c_n, d_n;
  logic          sel;
  logic          tmo;

  // A tie goes to whoever was not served last.
  assign sel = (req == 2'b11) ? ~last : req[1];

  // Counter holds 0 in the first start cycle, so this value on an edge
  // means the job has been running for TIMEOUT cycles after it.
  assign tmo = (tcnt == TW'(TIMEOUT - 1));

  assign mcc_reset = reset | (state == RECOVER);

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    last_n  = last;
    scnt_n  = scnt;
    tcnt_n  = tcnt;
    ack_n   = 2'b00;
    rv_n    = 2'b00;
    res_n   = rsp_result;
    err_n   = 1'b0;
    start_n = mcc_start;
    mode_n  = mcc_mode;
    a_n     = mcc_a;
    b_n     = mcc_b;
    c_n     = mcc_c;
    d_n     = mcc_d;
    if (state != IDLE) begin
      tcnt_n = tcnt + 1'b1;
    end
    unique case (state)
      IDLE: begin
        if (|req) begin
          gnt_n      = sel;
          last_n     = sel;
          ack_n[sel] = 1'b1;
          start_n    = 1'b1;
          mode_n     = req_mode[sel];
          a_n        = sel ? req_a[15:8] : req_a[7:0];
          b_n        = sel ? req_b[15:8] : req_b[7:0];
          c_n        = sel ? req_c[15:8] : req_c[7:0];
          d_n        = sel ? req_d[15:8] : req_d[7:0];
          scnt_n     = '0;
          tcnt_n     = '0;
          state_n    = START;
        end
      end
      START: begin
        if (scnt == SW'(START_CYCLES - 1)) begin
          start_n = 1'b0;
          state_n = WAIT_LOW;
        end else begin
          scnt_n = scnt + 1'b1;
        end
      end
      WAIT_LOW: begin
        if (tmo) begin
          rv_n[gnt] = 1'b1;
          err_n     = 1'b1;
          res_n     = 8'h00;
          state_n   = RECOVER;
        end else if (!mcc_done) begin
          state_n = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (tmo) begin
          rv_n[gnt] = 1'b1;
          err_n     = 1'b1;
          res_n     = 8'h00;
          state_n   = RECOVER;
        end else if (mcc_done) begin
          rv_n[gnt] = 1'b1;
          res_n     = mcc_result;
          state_n   = RESP;
        end
      end
      RESP:    state_n = IDLE;
      RECOVER: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last       <= 1'b1;
      scnt       <= '0;
      tcnt       <= '0;
      ack        <= 2'b00;
      rsp_valid  <= 2'b00;
      rsp_result <= 8'h00;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      mcc_start  <= 1'b0;
      mcc_mode   <= 1'b0;
      mcc_a      <= 8'h00;
      mcc_b      <= 8'h00;
      mcc_c      <= 8'h00;
      mcc_d      <= 8'h00;
    end else begin
      state      <= state_n;
      gnt        <= gnt_n;
      last       <= last_n;
      scnt       <= scnt_n;
      tcnt       <= tcnt_n;
      ack        <= ack_n;
      rsp_valid  <= rv_n;
      rsp_result <= res_n;
      rsp_err    <= err_n;
      busy       <= busy_n;
      mcc_start  <= start_n;
      mcc_mode   <= mode_n;
      mcc_a      <= a_n;
      mcc_b      <= b_n;
      mcc_c      <= c_n;
      mcc_d      <= d_n;
    end
  end

endmodule

// File: tb/tb_mcc_job_arbiter.sv
// tb_mcc_job_arbiter: self-checking bench for mcc_job_arbiter with a
// behavioural datapath stub and a round-robin reference model.
module tb_mcc_job_arbiter;

  localparam int SC   = 2;
  localparam int TO   = 64;
  localparam int SLAT = 4;
  // first start cycle -> response: start cycles, fall detect,
  // stub turnaround, done edge, response edge
  localparam int EXP_RLAT = SC + SLAT + 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req, req_mode;
  logic [15:0] req_a, req_b, req_c, req_d;
  logic [1:0]  ack, rsp_valid;
  logic [7:0]  rsp_result;
  logic        rsp_err, busy;
  logic        mcc_start, mcc_mode, mcc_reset;
  logic [7:0]  mcc_a, mcc_b, mcc_c, mcc_d;
  logic        mcc_done;
  logic [7:0]  mcc_result;

  int n_chk  = 0;
  int n_fail = 0;
  int mlast;
  logic [7:0] ma[2], mb[2], mc[2], md[2];
  logic       mm[2];

  always #5 clock = ~clock;

  mcc_job_arbiter #(.START_CYCLES(SC), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req(req), .req_mode(req_mode),
    .req_a(req_a), .req_b(req_b),
    .req_c(req_c), .req_d(req_d),
    .ack(ack), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .busy(busy), .mcc_start(mcc_start),
    .mcc_mode(mcc_mode),
    .mcc_a(mcc_a), .mcc_b(mcc_b),
    .mcc_c(mcc_c), .mcc_d(mcc_d),
    .mcc_reset(mcc_reset),
    .mcc_done(mcc_done), .mcc_result(mcc_result)
  );

  // Datapath stub
  bit   hang = 0;
  logic prev_start;
  int   stub_cnt;
  always @(posedge clock) begin
    if (mcc_reset) begin
      mcc_done   <= 1'b0;
      mcc_result <= 8'h00;
      prev_start <= 1'b0;
      stub_cnt   <= 0;
    end else begin
      prev_start <= mcc_start;
      if (prev_start && !mcc_start) begin
        mcc_done <= 1'b0;
        stub_cnt <= SLAT;
      end else if (stub_cnt > 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1 && !hang) begin
          mcc_done   <= 1'b1;
          mcc_result <= mcc_a ^ mcc_b ^ mcc_c ^ mcc_d;
        end
      end
    end
  end

  function automatic logic [7:0] exp_res(int g);
    return ma[g] ^ mb[g] ^ mc[g] ^ md[g];
  endfunction

  task automatic set_ops(int i, logic m, logic [7:0] a,
                         logic [7:0] b, logic [7:0] c,
                         logic [7:0] d);
    ma[i] = a; mb[i] = b; mc[i] = c; md[i] = d; mm[i] = m;
    req_mode[i]    = m;
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    req_c[8*i +: 8] = c;
    req_d[8*i +: 8] = d;
  endtask

  task automatic set_rand(int i);
    set_ops(i, 1'($urandom_range(0, 1)), 8'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // Observes one job from the current negedge; records, never judges.
  task automatic observe(input bit hold,
                         output logic [1:0] ackv,
                         output int acklat,
                         output logic [31:0] ops,
                         output logic om, output logic bz,
                         output int slen, output int rlat,
                         output logic [1:0] rv,
                         output logic [7:0] res,
                         output logic er, output int nrst,
                         output bit tmo);
    int c = 0;
    int s0 = -1;
    bit ga = 0;
    bit gr = 0;
    ackv = 0; acklat = -1; ops = 0; om = 0; bz = 0;
    slen = 0; rlat = -1; rv = 0; res = 0; er = 0; nrst = 0;
    while (!gr && c < 200) begin
      @(negedge clock);
      c++;
      if (!ga && ack != 2'b00) begin
        ga = 1; ackv = ack; acklat = c;
        ops = {mcc_a, mcc_b, mcc_c, mcc_d};
        om = mcc_mode; bz = busy;
        if (!hold) req = req & ~ack;
      end
      if (mcc_start) begin
        slen++;
        if (s0 < 0) s0 = c;
      end
      if (mcc_reset) nrst++;
      if (rsp_valid != 2'b00) begin
        gr = 1; rv = rsp_valid; res = rsp_result;
        er = rsp_err; rlat = c - s0;
      end
    end
    tmo = !gr;
    if (gr) begin
      @(negedge clock);
      if (mcc_reset) nrst++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = 2'b00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    mlast = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 2'b00;
    set_ops(0, 0, 0, 0, 0, 0);
    set_ops(1, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    n_chk++;
    if ({ack, rsp_valid, rsp_err, busy, mcc_start} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 0",
               {ack, rsp_valid, rsp_err, busy, mcc_start});
    end
    n_chk++;
    if ({rsp_result, mcc_mode, mcc_a, mcc_b, mcc_c, mcc_d} !== 41'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0",
               {rsp_result, mcc_mode, mcc_a, mcc_b, mcc_c, mcc_d});
    end
    n_chk++;
    if (mcc_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mcc_reset: got %b want 1", mcc_reset);
    end
    reset = 1'b0;
    mlast = 1;
    @(negedge clock);
    n_chk++;
    if ({mcc_reset, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset: got %b want 00", {mcc_reset, busy});
    end
  endtask

  task automatic test_single();
    logic [1:0] ackv, rv;
    logic [31:0] ops;
    logic om, bz, er;
    logic [7:0] res;
    int al, sl, rl, nr;
    bit tmo;
    set_ops(0, 0, 8'h01, 8'h02, 8'hFF, 8'hFE);
    req = 2'b01;
    observe(0, ackv, al, ops, om, bz, sl, rl, rv, res, er, nr, tmo);
    n_chk++;
    if (tmo !== 1'b0) begin
      n_fail++; $display("FAIL single_timeout: got 1 want 0");
    end
    n_chk++;
    if (ackv !== 2'b01 || al !== 1) begin
      n_fail++;
      $display("FAIL single_ack: got %b@%0d want 01@1", ackv, al);
    end
    n_chk++;
    if (sl !== SC) begin
      n_fail++; $display("FAIL single_start_len: got %0d want %0d", sl, SC);
    end
    n_chk++;
    if (ops !== {ma[0], mb[0], mc[0], md[0]} || om !== mm[0] || bz !== 1'b1)
    begin
      n_fail++;
      $display("FAIL single_ops: got %h/%b/%b want %h/%b/1", ops, om, bz,
               {ma[0], mb[0], mc[0], md[0]}, mm[0]);
    end
    n_chk++;
    if (rv !== 2'b01 || res !== 8'h02 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rsp: got %b/%h/%b want 01/02/0", rv, res, er);
    end
    n_chk++;
    if (rl !== EXP_RLAT || nr !== 0) begin
      n_fail++;
      $display("FAIL single_lat: got %0d/%0d want %0d/0", rl, nr, EXP_RLAT);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL single_idle_busy: got %b want 0", busy);
    end
    mlast = 0;
  endtask

  task automatic test_round_robin();
    logic [1:0] ackv, rv;
    logic [31:0] ops;
    logic om, bz, er;
    logic [7:0] res;
    int al, sl, rl, nr, g;
    bit tmo;
    do_reset();
    set_ops(0, 0, 8'hFE, 8'h01, 8'h01, 8'h04);
    set_ops(1, 1, 8'h01, 8'hFF, 8'hFF, 8'hFF);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      g = (mlast == 0) ? 1 : 0;
      observe(1, ackv, al, ops, om, bz, sl, rl, rv, res, er, nr, tmo);
      n_chk++;
      if (ackv !== 2'(1 << g) || rv !== 2'(1 << g)) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got ack %b rsp %b want owner %0d",
                 k, ackv, rv, g);
      end
      n_chk++;
      if (res !== exp_res(g) || om !== mm[g] || tmo) begin
        n_fail++;
        $display("FAIL rr_result%0d: got %h/%b want %h/%b", k, res, om,
                 exp_res(g), mm[g]);
      end
      mlast = g;
    end
    req = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [1:0] ackv, rv;
    logic [31:0] ops;
    logic om, bz, er;
    logic [7:0] res;
    int al, sl, rl, nr;
    bit tmo;
    set_ops(1, 0, 8'hFF, 8'h01, 8'h01, 8'hFF);
    for (int k = 0; k < 2; k++) begin
      req = 2'b10;
      observe(0, ackv, al, ops, om, bz, sl, rl, rv, res, er, nr, tmo);
      n_chk++;
      if (ackv !== 2'b10 || rv !== 2'b10 || res !== exp_res(1)) begin
        n_fail++;
        $display("FAIL b2b_rsp%0d: got %b/%b/%h want 10/10/%h", k, ackv, rv,
                 res, exp_res(1));
      end
      n_chk++;
      if (rl !== EXP_RLAT) begin
        n_fail++;
        $display("FAIL b2b_lat%0d: got %0d want %0d", k, rl, EXP_RLAT);
      end
    end
    mlast = 1;
  endtask

  task automatic test_timeout();
    logic [1:0] ackv, rv;
    logic [31:0] ops;
    logic om, bz, er;
    logic [7:0] res;
    int al, sl, rl, nr;
    bit tmo;
    hang = 1;
    set_rand(0);
    req = 2'b01;
    observe(0, ackv, al, ops, om, bz, sl, rl, rv, res, er, nr, tmo);
    n_chk++;
    if (rv !== 2'b01 || er !== 1'b1 || res !== 8'h00) begin
      n_fail++;
      $display("FAIL tmo_rsp: got %b/%b/%h want 01/1/00", rv, er, res);
    end
    n_chk++;
    if (rl !== TO) begin
      n_fail++; $display("FAIL tmo_lat: got %0d want %0d", rl, TO);
    end
    n_chk++;
    if (nr !== 1) begin
      n_fail++; $display("FAIL tmo_mcc_reset: got %0d cycles want 1", nr);
    end
    hang = 0;
    set_rand(0);
    req = 2'b01;
    observe(0, ackv, al, ops, om, bz, sl, rl, rv, res, er, nr, tmo);
    n_chk++;
    if (rv !== 2'b01 || er !== 1'b0 || res !== exp_res(0) ||
        rl !== EXP_RLAT || nr !== 0) begin
      n_fail++;
      $display("FAIL tmo_next: got %b/%b/%h/%0d/%0d want 01/0/%h/%0d/0",
               rv, er, res, rl, nr, exp_res(0), EXP_RLAT);
    end
    mlast = 0;
  endtask

  task automatic test_reset_mid_job();
    logic [1:0] ackv, rv;
    logic [31:0] ops;
    logic om, bz, er;
    logic [7:0] res;
    int al, sl, rl, nr, w;
    bit tmo, seen;
    set_rand(0);
    req = 2'b01;
    w = 0;
    do begin
      @(negedge clock);
      w++;
    end while (ack === 2'b00 && w < 8);
    req = 2'b00;
    n_chk++;
    if (ack !== 2'b01) begin
      n_fail++; $display("FAIL mid_ack: got %b want 01", ack);
    end
    repeat (4) @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_chk++;
      if ({ack, rsp_valid, rsp_err, busy, mcc_start, mcc_mode, mcc_reset}
          !== 9'b000000001 ||
          {rsp_result, mcc_a, mcc_b, mcc_c, mcc_d} !== 40'h0) begin
        n_fail++;
        $display("FAIL mid_reset%0d: got %b %h want 000000001 0", k,
                 {ack, rsp_valid, rsp_err, busy, mcc_start, mcc_mode,
                  mcc_reset},
                 {rsp_result, mcc_a, mcc_b, mcc_c, mcc_d});
      end
    end
    reset = 1'b0;
    mlast = 1;
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (rsp_valid !== 2'b00) seen = 1;
    end
    n_chk++;
    if (seen) begin
      n_fail++; $display("FAIL mid_no_rsp: got rsp_valid want none");
    end
    set_rand(0);
    set_rand(1);
    req = 2'b11;
    for (int k = 0; k < 2; k++) begin
      observe(0, ackv, al, ops, om, bz, sl, rl, rv, res, er, nr, tmo);
      n_chk++;
      if (ackv !== 2'(1 << k) || res !== exp_res(k) || tmo) begin
        n_fail++;
        $display("FAIL mid_after%0d: got %b/%h want %b/%h", k, ackv, res,
                 2'(1 << k), exp_res(k));
      end
      mlast = k;
    end
    req = 2'b00;
  endtask

  task automatic test_random();
    logic [1:0] ackv, rv, pend;
    logic [31:0] ops;
    logic om, bz, er;
    logic [7:0] res;
    int al, sl, rl, nr, g;
    bit tmo;
    pend = 2'b00;
    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          set_rand(i);
          pend[i] = 1'b1;
        end
      end
      if (pend == 2'b00) begin
        g = int'($urandom_range(0, 1));
        set_rand(g);
        pend[g] = 1'b1;
      end
      req = pend;
      g = (pend == 2'b11) ? 1 - mlast : (pend[1] ? 1 : 0);
      observe(0, ackv, al, ops, om, bz, sl, rl, rv, res, er, nr, tmo);
      n_chk++;
      if (ackv !== 2'(1 << g) || rv !== 2'(1 << g) || tmo) begin
        n_fail++;
        $display("FAIL rand%0d_grant: got %b/%b want owner %0d",
                 it, ackv, rv, g);
      end
      n_chk++;
      if (ops !== {ma[g], mb[g], mc[g], md[g]} || om !== mm[g]) begin
        n_fail++;
        $display("FAIL rand%0d_ops: got %h/%b want %h/%b", it, ops, om,
                 {ma[g], mb[g], mc[g], md[g]}, mm[g]);
      end
      n_chk++;
      if (res !== exp_res(g) || er !== 1'b0 || rl !== EXP_RLAT) begin
        n_fail++;
        $display("FAIL rand%0d_rsp: got %h/%b/%0d want %h/0/%0d", it, res,
                 er, rl, exp_res(g), EXP_RLAT);
      end
      pend[g] = 1'b0;
      mlast = g;
    end
    req = 2'b00;
  endtask

  initial begin
    reset = 1'b1;
    req = 2'b00;
    req_mode = 2'b00;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_timeout();
    test_reset_mid_job();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
